wrr_arbiter: RTL and testbench

//   Parametrised weighted round-robin arbiter. Successor to the fixed 4-way rr_arbiter.

---
 rtl/wrr_arbiter_pkg.sv | 23 ++
 rtl/wrr_arbiter_rr_pick.sv | 29 ++
 rtl/wrr_arbiter.sv | 123 ++++++++++++
 tb/tb_wrr_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Provides the FSM state encoding and a one-hot to index encoder.
package wrr_arbiter_pkg;

  localparam int MAX_N     = 64;
  localparam int MAX_IDX_W = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } wrr_state_e;

  // Returns the index of the set bit; an all-zero vector encodes to 0.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set req bit scanning
// circularly upward from ptr, with ptr itself at top priority.
module rr_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    logic [IDX_W:0] pos;
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    // Scan from the far end back toward ptr so the closest hit wins last.
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (pos >= (IDX_W + 1)'(N)) pos = pos - (IDX_W + 1)'(N);
      if (req[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: grants one requester for up to w_eff
// consecutive cycles, then rotates priority past the previous owner.
module wrr_arbiter
  import wrr_arbiter_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int WEIGHT_W = 4,
  localparam int IDX_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          req,
  input  logic [N*WEIGHT_W-1:0] weight,
  output logic [N-1:0]          grant,
  output logic                  grant_valid,
  output logic [IDX_W-1:0]      grant_idx
);

  wrr_state_e           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]  credit_q, credit_d;
  logic [N-1:0]         grant_q, grant_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;

  logic [IDX_W-1:0]     next_ptr;
  logic [IDX_W-1:0]     pick_ptr;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic                 hold;
  logic [MAX_N-1:0]     grant_ext;

  // A zero weight still buys one cycle of grant.
  function automatic logic [WEIGHT_W-1:0] w_eff(input logic [N*WEIGHT_W-1:0] w,
                                                 input logic [IDX_W-1:0]      i);
    logic [WEIGHT_W-1:0] f;
    f = w[int'(i)*WEIGHT_W +: WEIGHT_W];
    return (f == '0) ? WEIGHT_W'(1) : f;
  endfunction

  assign next_ptr = (grant_idx_q == IDX_W'(N - 1)) ? '0 : grant_idx_q + IDX_W'(1);
  assign pick_ptr = (state_q == GRANT) ? next_ptr : ptr_q;
  assign hold     = (state_q == GRANT) && req[grant_idx_q] && (credit_q != '0);

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    grant_d  = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          credit_d          = w_eff(weight, pick_idx) - WEIGHT_W'(1);
          state_d           = GRANT;
        end else begin
          grant_d = '0;
        end
      end
      GRANT: begin
        if (hold) begin
          credit_d = credit_q - WEIGHT_W'(1);
        end else begin
          // Burst over or owner dropped: move priority past the owner and re-pick.
          ptr_d = next_ptr;
          if (pick_found) begin
            grant_d           = '0;
            grant_d[pick_idx] = 1'b1;
            credit_d          = w_eff(weight, pick_idx) - WEIGHT_W'(1);
          end else begin
            grant_d  = '0;
            credit_d = '0;
            state_d  = IDLE;
          end
        end
      end
      default: begin
        grant_d  = '0;
        credit_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  always_comb begin
    grant_ext            = '0;
    grant_ext[N-1:0]     = grant_d;
    grant_idx_d          = IDX_W'(onehot_to_idx(grant_ext));
    grant_valid_d        = |grant_d;
  end

  // Registered state and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      credit_q      <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      credit_q      <= credit_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: directed scenarios plus randomized
// traffic compared against a burst-counting reference model.
module tb_wrr_arbiter;

  localparam int N        = 4;
  localparam int WEIGHT_W = 4;
  localparam int IDX_W    = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          req;
  logic [N*WEIGHT_W-1:0] weight;
  logic [N-1:0]          grant;
  logic                  grant_valid;
  logic [IDX_W-1:0]      grant_idx;

  always #5 clk = ~clk;

  wrr_arbiter #(.N(N), .WEIGHT_W(WEIGHT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .weight      (weight),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: owner, cycles used in current burst, burst length, priority pointer.
  int m_owner = -1;
  int m_used  = 0;
  int m_len   = 0;
  int m_ptr   = 0;
  int wait_c[N];
  int wmax[N];

  function automatic int weff(input int i, input logic [N*WEIGHT_W-1:0] w);
    int v;
    v = int'(w[i*WEIGHT_W +: WEIGHT_W]);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int pick(input int from, input logic [N-1:0] r);
    for (int off = 0; off < N; off++) begin
      if (r[(from + off) % N]) return (from + off) % N;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [N-1:0] r, input logic [N*WEIGHT_W-1:0] w, input logic rs);
    int j;
    if (rs) begin
      m_owner = -1;
      m_ptr   = 0;
      m_used  = 0;
      for (int i = 0; i < N; i++) wmax[i] = weff(i, w);
    end else begin
      for (int i = 0; i < N; i++) if (weff(i, w) > wmax[i]) wmax[i] = weff(i, w);
      if (m_owner < 0) begin
        j = pick(m_ptr, r);
        if (j >= 0) begin m_owner = j; m_used = 1; m_len = weff(j, w); end
      end else if (r[m_owner] && m_used < m_len) begin
        m_used++;
      end else begin
        m_ptr = (m_owner + 1) % N;
        j = pick(m_ptr, r);
        if (j >= 0) begin m_owner = j; m_used = 1; m_len = weff(j, w); end
        else m_owner = -1;
      end
    end
  endtask

  task automatic check_outputs(input logic [N-1:0] r, input logic rs);
    logic [N-1:0] exp_g;
    int bound;
    exp_g = (m_owner < 0) ? '0 : N'(1) << m_owner;
    check_eq("grant", 32'(grant), 32'(exp_g));
    check_eq("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
    check_eq("grant_idx", 32'(grant_idx), (m_owner < 0) ? 0 : m_owner);
    check_eq("onehot0", 32'($onehot0(grant)), 1);
    check_eq("valid_is_or", 32'(grant_valid), 32'(|grant));
    check_eq("grant_in_req", 32'(grant & ~r), 0);
    check_eq("work_cons", 32'(grant_valid), 32'(!rs && (r != '0)));
    for (int i = 0; i < N; i++) begin
      if (rs || !r[i] || grant[i]) wait_c[i] = 0;
      else wait_c[i]++;
      bound = 1;
      for (int j = 0; j < N; j++) if (j != i) bound += wmax[j];
      check_eq($sformatf("fair%0d", i), 32'(wait_c[i] <= bound), 1);
    end
  endtask

  task automatic step();
    logic [N-1:0]          r;
    logic [N*WEIGHT_W-1:0] w;
    logic                  rs;
    r  = req;
    w  = weight;
    rs = reset;
    @(posedge clk);
    model_edge(r, w, rs);
    #1;
    check_outputs(r, rs);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin wait_c[i] = 0; wmax[i] = 1; end
    reset  = 1'b1;
    req    = 4'hF;
    weight = 16'h1111;

    // Reset held with all requests up
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("rst_grant", 32'(grant), 0);
      check_eq("rst_valid", 32'(grant_valid), 0);
      check_eq("rst_idx", 32'(grant_idx), 0);
    end

    // Equal unit weights rotate one cycle each
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check_eq("rot_equal", 32'(grant), 32'(1 << (k % 4)));
    end

    // weight {1,1,1,3}, req 0011: three cycles to 0, one to 1
    do_reset();
    weight = 16'h1113;
    req    = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      step();
      check_eq("weighted", 32'(grant), (k % 4 < 3) ? 32'h1 : 32'h2);
    end

    // Owner drops early: handoff with no idle gap, then req3 wins over req1
    do_reset();
    weight = 16'h1411;
    req    = 4'b0100;
    step();
    check_eq("drop_own", 32'(grant), 32'h4);
    req = 4'b0010;
    step();
    check_eq("drop_handoff", 32'(grant), 32'h2);
    req = 4'b1010;
    step();
    check_eq("drop_ptr", 32'(grant), 32'h8);

    // Zero weight, single requester: re-granted every cycle, then idle
    do_reset();
    weight = 16'h0000;
    req    = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("single", 32'(grant), 32'h4);
    end
    req = 4'b0000;
    step();
    check_eq("single_drop", 32'(grant), 0);
    check_eq("single_dropv", 32'(grant_valid), 0);

    // Reset in the middle of a long burst
    do_reset();
    weight = 16'h0008;
    req    = 4'b0001;
    for (int k = 0; k < 3; k++) step();
    check_eq("mid_burst", 32'(grant), 32'h1);
    reset = 1'b1;
    step();
    check_eq("mid_rst", 32'(grant), 0);
    reset = 1'b0;
    req   = 4'hF;
    step();
    check_eq("post_rst", 32'(grant), 32'h1);

    // Randomized traffic; last phase also changes weights every cycle
    for (int ph = 0; ph < 3; ph++) begin
      do_reset();
      weight = $urandom;
      for (int k = 0; k < 400; k++) begin
        req = req ^ N'($urandom & $urandom & $urandom);
        if (ph == 2) weight = $urandom;
        if (ph == 1 && k % 97 == 50) reset = 1'b1;
        step();
        reset = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
